// File: rtl/decode_buffer.sv
// IF->ID decode buffer: DEPTH-entry FIFO behind one registered decode slot; 1-cycle latency when empty.
// Backpressure: in_ready drops when the FIFO is full or on flush; the slot holds bit-for-bit while out_ready is low.
module decode_buffer #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [PC_W-1:0]              i_in_pc,
    input  logic [31:0]                  i_in_inst,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [PC_W-1:0]              o_out_pc,
    output logic [4:0]                   o_rs1_index,
    output logic [4:0]                   o_rs2_index,
    output logic [4:0]                   o_rd_index,
    output logic [4:0]                   o_opcode,
    output logic [3:0]                   o_func,
    output logic                         o_is_mtype,
    output logic                         o_is_fsub,
    output logic [1:0]                   o_csr_op,
    output logic [31:0]                  o_imm,
    output logic                         o_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [4:0]      opcode;
        logic [3:0]      func;
        logic            is_mtype;
        logic            is_fsub;
        logic [1:0]      csr_op;
        logic [31:0]     imm;
        logic            illegal;
    } dec_t;

    function automatic dec_t decode(input logic [PC_W-1:0] pc, input logic [31:0] inst);
        dec_t d;
        logic legal;
        d        = '0;
        legal    = 1'b1;
        d.pc     = pc;
        d.rs1    = inst[19:15];
        d.rs2    = inst[24:20];
        d.rd     = inst[11:7];
        d.opcode = inst[6:2];
        d.func   = {inst[14:12], inst[30]};
        d.is_mtype = inst[25] && (inst[6:2] == 5'b01100);
        d.is_fsub  = inst[27] && (inst[6:2] == 5'b10100);
        d.csr_op   = (inst[6:2] == 5'b11100) ? {inst[27], inst[21]} : 2'b00;
        case (inst[6:2])
            5'b00000, 5'b00001, 5'b00100, 5'b11001, 5'b11100:
                d.imm = {{20{inst[31]}}, inst[31:20]};
            5'b01000, 5'b01001:
                d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            5'b11000:
                d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            5'b00101, 5'b01101:
                d.imm = {inst[31:12], 12'b0};
            5'b11011:
                d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            5'b01100, 5'b10100:
                d.imm = 32'b0;
            default: begin
                d.imm = 32'b0;
                legal = 1'b0;
            end
        endcase
        d.illegal = (inst[1:0] != 2'b11) || !legal;
        return d;
    endfunction

    logic [PC_W+31:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_out_valid;
    dec_t              r_slot;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_load;
    logic              w_fifo_nonempty;
    logic              w_pop;
    logic              w_bypass;
    logic              w_push;
    logic [PC_W+31:0]  w_head;
    dec_t              w_dec;

    assign w_in_ready      = !i_flush && (r_count < FULL_CNT);
    assign w_accept        = i_in_valid && w_in_ready;
    assign w_load          = !r_out_valid || i_out_ready;
    assign w_fifo_nonempty = (r_count != '0);
    assign w_pop           = w_load && w_fifo_nonempty;
    assign w_bypass        = w_load && !w_fifo_nonempty && w_accept;
    assign w_push          = w_accept && !w_bypass;
    assign w_head          = r_mem[r_rd_ptr];
    // FIFO contents always take priority over the input so ordering is preserved.
    assign w_dec = w_fifo_nonempty ? decode(w_head[PC_W+31:32], w_head[31:0])
                                   : decode(i_in_pc, i_in_inst);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_in_pc, i_in_inst};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_slot      <= '0;
        end else if (i_flush) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_load) begin
                r_out_valid <= w_pop || w_bypass;
                if (w_pop || w_bypass) begin
                    r_slot <= w_dec;
                end
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_pc    = r_slot.pc;
    assign o_rs1_index = r_slot.rs1;
    assign o_rs2_index = r_slot.rs2;
    assign o_rd_index  = r_slot.rd;
    assign o_opcode    = r_slot.opcode;
    assign o_func      = r_slot.func;
    assign o_is_mtype  = r_slot.is_mtype;
    assign o_is_fsub   = r_slot.is_fsub;
    assign o_csr_op    = r_slot.csr_op;
    assign o_imm       = r_slot.imm;
    assign o_illegal   = r_slot.illegal;
    assign o_count     = r_count;
endmodule

// File: tb/tb_decode_buffer.sv
// Directed bench for decode_buffer: bypass, immediates, fill/drain, wrap, flush, CSR/illegal, async reset.
module tb_decode_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rs1_index, rs2_index, rd_index, opcode;
    logic [3:0]  func;
    logic        is_mtype, is_fsub, illegal;
    logic [1:0]  csr_op;
    logic [31:0] imm;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_buffer #(.DEPTH(4), .PC_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_pc(in_pc), .i_in_inst(in_inst),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_pc(out_pc), .o_rs1_index(rs1_index), .o_rs2_index(rs2_index),
        .o_rd_index(rd_index), .o_opcode(opcode), .o_func(func),
        .o_is_mtype(is_mtype), .o_is_fsub(is_fsub), .o_csr_op(csr_op),
        .o_imm(imm), .o_illegal(illegal), .o_count(count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] imm_inst [4];
    logic [31:0] imm_exp  [4];

    initial begin
        imm_inst = '{32'hFFC10093, 32'hFE112E23, 32'hFE000EE3, 32'h123452B7};
        imm_exp  = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_imm", imm, 0);
        check("rst_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Bypass: mul a0,a1,a2 into an empty buffer.
        in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h02C58533; out_ready = 1'b1;
        tick();
        check("byp_valid", out_valid, 1);
        check("byp_pc", out_pc, 32'h100);
        check("byp_rs1", rs1_index, 11);
        check("byp_rs2", rs2_index, 12);
        check("byp_rd", rd_index, 10);
        check("byp_opcode", opcode, 5'b01100);
        check("byp_mtype", is_mtype, 1);
        check("byp_func", func, 4'b0000);
        check("byp_illegal", illegal, 0);
        check("byp_count", count, 0);

        for (int i = 0; i < 4; i++) begin
            in_inst = imm_inst[i];
            in_pc   = 32'(32'h180 + 4 * i);
            tick();
            check("imm_stream", imm, imm_exp[i]);
        end
        in_valid = 1'b0;
        tick();
        check("imm_drained", out_valid, 0);

        // Fill: slot + 4 FIFO entries, sixth offer refused.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'(32'h200 + 4 * k);
            in_inst  = 32'h00000013 | 32'(k << 7);
            tick();
        end
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        check("full_slot_pc", out_pc, 32'h200);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("drain_valid", out_valid, 1);
            check("drain_pc", out_pc, 32'(32'h200 + 4 * k));
            check("drain_rd", rd_index, 5'(k));
            tick();
        end
        check("drain_empty", out_valid, 0);
        check("drain_count", count, 0);

        // Simultaneous push/pop at count=2 across pointer wrap.
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1;
            in_pc    = 32'(32'h300 + 4 * n);
            in_inst  = 32'h00000013;
            tick();
        end
        check("wrap_pre_count", count, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_pc = 32'(32'h300 + 4 * (3 + i));
            tick();
            check("wrap_count", count, 2);
            check("wrap_pc", out_pc, 32'(32'h300 + 4 * (1 + i)));
        end
        in_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            tick();
            check("wrap_tail_pc", out_pc, 32'(32'h300 + 4 * (9 + j)));
        end
        tick();
        check("wrap_empty", out_valid, 0);

        // Flush with count=3 and a pending offer.
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1;
            in_pc    = 32'(32'h400 + 4 * n);
            in_inst  = 32'h00000013;
            tick();
        end
        check("pre_flush_count", count, 3);
        check("pre_flush_valid", out_valid, 1);
        flush = 1'b1; in_pc = 32'h000DEAD0; in_inst = 32'h02C58533; out_ready = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_count", count, 0);
        tick();
        tick();
        check("flush_dropped", out_valid, 0);
        in_valid = 1'b1; in_pc = 32'h500; in_inst = 32'h00000013;
        tick();
        check("post_flush_pc", out_pc, 32'h500);
        check("post_flush_valid", out_valid, 1);

        // Illegal / CSR / F decode.
        in_pc = 32'h510; in_inst = 32'h00000000;
        tick();
        check("ill_zero", illegal, 1);
        check("ill_imm", imm, 0);
        in_inst = 32'h30002573;
        tick();
        check("csrrs_opcode", opcode, 5'b11100);
        check("csrrs_csrop", csr_op, 2'b00);
        check("csrrs_imm", imm, 32'h00000300);
        check("csrrs_illegal", illegal, 0);
        in_inst = 32'h08000053;
        tick();
        check("fsub_flag", is_fsub, 1);
        check("fsub_opcode", opcode, 5'b10100);
        check("fsub_illegal", illegal, 0);
        in_inst = 32'h08200073;
        tick();
        check("csr11_csrop", csr_op, 2'b11);
        check("csr11_imm", imm, 32'h00000082);
        in_valid = 1'b0;
        tick();

        // Async reset during a stall.
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h600; in_inst = 32'h30002573;
        tick();
        in_valid = 1'b0;
        check("stall_valid", out_valid, 1);
        tick();
        check("stall_pc_held", out_pc, 32'h600);
        check("stall_imm_held", imm, 32'h300);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_pc", out_pc, 0);
        check("arst_imm", imm, 0);
        check("arst_opcode", opcode, 0);
        check("arst_rs1", rs1_index, 0);
        #2;
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_buffer.md
# decode_buffer

Parametrised instruction decode buffer between IF and ID. Queues fetched {pc, inst} pairs in a DEPTH-entry FIFO, decodes the head into register indices, opcode/func, M/F/CSR qualifiers, a sign-extended immediate and an illegal flag, and presents them in a registered output slot with a valid/ready handshake. Absorbs fetch/decode rate mismatch; supports same-cycle flush on redirect.

## Interface
- DEPTH, 4: FIFO entries behind the output slot; power of 2, ≥2. Total capacity DEPTH+1.
- PC_W, 32: PC width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush (branch/trap redirect).
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  buffer accepts; = !flush && (count < DEPTH).
- in_pc  in  PC_W  instruction PC.
- in_inst  in  32  raw instruction.
- out_valid  out  1  output slot holds a decoded instruction.
- out_ready  in  1  ID consumes slot this cycle.
- out_pc  out  PC_W  PC of slot instruction.
- rs1_index, rs2_index, rd_index  out  5 each  inst[19:15], inst[24:20], inst[11:7].
- opcode  out  5  inst[6:2].
- func  out  4  {inst[14:12], inst[30]}.
- is_mtype  out  1  inst[25] && opcode==5'b01100.
- is_fsub  out  1  inst[27] && opcode==5'b10100.
- csrOp  out  2  {inst[27], inst[21]} when opcode==5'b11100, else 0.
- imm  out  32  sign-extended immediate (below).
- illegal  out  1  unrecognised encoding.
- count  out  $clog2(DEPTH+1)  FIFO occupancy (excludes output slot).

## Operation
- Decode is combinational on the selected source (FIFO head or bypassed input) and captured into the output slot registers; outputs are never combinational from in_*.
- imm: I-type (opcodes 00000, 00001, 00100, 11001, 11100) sext(inst[31:20]); S (01000, 01001) sext({inst[31:25],inst[11:7]}); B (11000) sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U (00101, 01101) {inst[31:12],12'b0}; J (11011) sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); else 0.
- illegal = 1 if inst[1:0] != 2'b11 or opcode not in {00000,00001,00100,00101,01000,01001,01100,01101,10100,11000,11001,11011,11100}. Illegal instructions still flow through; trap handling is downstream.
- Slot load condition L = !out_valid || out_ready. When L: if count>0, load FIFO head and pop; else if in_valid&&in_ready, load input directly (bypass, FIFO untouched); else out_valid←0.
- Input accepted and not bypassed is pushed at tail. Push and pop in same cycle leave count unchanged. Wrap-around of read/write pointers modulo DEPTH.
- Full (count==DEPTH): in_ready=0; slot and FIFO hold; no entry overwritten.
- flush=1: next edge clears out_valid, count, pointers; in_ready=0 that cycle so in_* is dropped; out_ready ignored. Flush wins over every simultaneous event.
- Reset (any time, including mid-transfer): out_valid=0, count=0, pointers=0, all decoded outputs, out_pc and imm = 0, illegal=0; in_ready=1 after release.

## Timing
- Latency: accepted input with empty buffer appears on out_valid next cycle (1 cycle).
- Throughput: 1 instruction/cycle sustained when out_ready=1.
- Stall (out_valid && !out_ready): all outputs held stable bit-for-bit.
- in_ready depends only on count and flush (no combinational path from out_ready).
- FIFO order preserved: output order equals acceptance order.

## Test plan
- Reset/bypass: rst_n low then high; in_inst=0x02C58533 (mul a0,a1,a2), pc=0x100 -> next cycle out_valid=1, rs1=11, rs2=12, rd=10, opcode=01100, is_mtype=1, func=0000, illegal=0.
- Immediates: stream 0xFFC10093 (addi -4), 0xFE112E23 (sw, -4), 0xFE000EE3 (beq, -4), 0x123452B7 (lui) -> imm 0xFFFFFFFC, 0xFFFFFFFC, 0xFFFFFFFC, 0x12345000 in order.
- Fill/full: out_ready=0, offer 6 instructions -> 5 accepted (slot+4), count=4, in_ready=0; then out_ready=1 -> 5 outputs in acceptance order, one per cycle.
- Simultaneous push/pop at count=2 with wrap: count stays 2 for 8 cycles, pointers wrap, order intact.
- Flush with count=3, out_valid=1, in_valid=1 -> next cycle out_valid=0, count=0, offered input absent from all later outputs.
- Illegal/CSR: inst 0x00000000 -> illegal=1; 0x30002573 (csrrs) -> opcode=11100, csrOp=00, imm=0x00000300, illegal=0; async reset asserted mid-stall clears outputs immediately.
